// File: rtl/id_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage_if
//  Description : Bundle of the decode-stage signals: the fetch-side input
//                handshake, the flush and execute-stage hazard inputs, and
//                the registered decode outputs toward execute.
//                slave  - used by id_stage
//                master - used by whatever drives fetch/execute side
//  Revision    : 1.0 - initial release
// ============================================================================
interface id_stage_if #(
    parameter int XLEN = 32
);
    // fetch side
    logic            in_valid_i;
    logic            in_ready_o;
    logic [31:0]     ins_i;
    logic [XLEN-1:0] ins_addr_i;
    // control / hazard inputs
    logic            flush_i;
    logic            ex_load_i;
    logic [4:0]      ex_rd_i;
    // execute side
    logic            out_valid_o;
    logic            out_ready_i;
    logic [31:0]     ins_o;
    logic [XLEN-1:0] ins_addr_o;
    logic [4:0]      rs1_addr_o;
    logic [4:0]      rs2_addr_o;
    logic [4:0]      rd_addr_o;
    logic [XLEN-1:0] imm_o;
    logic            illegal_o;

    modport slave (
        input  in_valid_i, ins_i, ins_addr_i, flush_i, ex_load_i, ex_rd_i,
               out_ready_i,
        output in_ready_o, out_valid_o, ins_o, ins_addr_o, rs1_addr_o,
               rs2_addr_o, rd_addr_o, imm_o, illegal_o
    );

    modport master (
        output in_valid_i, ins_i, ins_addr_i, flush_i, ex_load_i, ex_rd_i,
               out_ready_i,
        input  in_ready_o, out_valid_o, ins_o, ins_addr_o, rs1_addr_o,
               rs2_addr_o, rd_addr_o, imm_o, illegal_o
    );
endinterface
`default_nettype wire

// File: rtl/id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : id_stage
//  Description : Registered RV32I instruction-decode stage. Decodes register
//                addresses, sign-extended immediate and an illegal-opcode
//                flag from the fetched word, holds them in a valid/ready
//                pipeline register, inserts bubbles on load-use hazards
//                against execute and kills the held instruction on flush.
//  Ports       : clk  - clock, rising edge
//                rst  - synchronous active-high reset
//                bus  - id_stage_if.slave (fetch handshake, flush, hazard
//                       inputs, decoded outputs toward execute)
//  Revision    : 1.0 - initial release
// ============================================================================
module id_stage #(
    parameter int          XLEN    = 32,
    parameter logic [31:0] NOP_INS = 32'h0000_0013
) (
    input  logic       clk,
    input  logic       rst,
    id_stage_if.slave  bus
);

    localparam logic [6:0] c_opc_op_imm = 7'b0010011;
    localparam logic [6:0] c_opc_load   = 7'b0000011;
    localparam logic [6:0] c_opc_jalr   = 7'b1100111;
    localparam logic [6:0] c_opc_op     = 7'b0110011;
    localparam logic [6:0] c_opc_store  = 7'b0100011;
    localparam logic [6:0] c_opc_branch = 7'b1100011;
    localparam logic [6:0] c_opc_lui    = 7'b0110111;
    localparam logic [6:0] c_opc_auipc  = 7'b0010111;
    localparam logic [6:0] c_opc_jal    = 7'b1101111;

    // ------------------------------------------------------------------
    // Combinational decode of the incoming word
    // ------------------------------------------------------------------
    logic [31:0]     w_ins;
    logic [6:0]      w_opcode;
    logic            w_rs1_used;
    logic            w_rs2_used;
    logic            w_rd_used;
    logic            w_illegal;
    logic [31:0]     w_imm32;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm;

    assign w_ins    = bus.ins_i;
    assign w_opcode = w_ins[6:0];

    always_comb begin
        w_rs1_used = 1'b0;
        w_rs2_used = 1'b0;
        w_rd_used  = 1'b0;
        w_illegal  = 1'b0;
        w_imm32    = 32'd0;
        case (w_opcode)
            c_opc_op_imm, c_opc_load, c_opc_jalr: begin
                w_rs1_used = 1'b1;
                w_rd_used  = 1'b1;
                w_imm32    = {{20{w_ins[31]}}, w_ins[31:20]};
            end
            c_opc_op: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_rd_used  = 1'b1;
            end
            c_opc_store: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_imm32    = {{20{w_ins[31]}}, w_ins[31:25], w_ins[11:7]};
            end
            c_opc_branch: begin
                w_rs1_used = 1'b1;
                w_rs2_used = 1'b1;
                w_imm32    = {{19{w_ins[31]}}, w_ins[31], w_ins[7],
                              w_ins[30:25], w_ins[11:8], 1'b0};
            end
            c_opc_lui, c_opc_auipc: begin
                w_rd_used  = 1'b1;
                w_imm32    = {w_ins[31:12], 12'd0};
            end
            c_opc_jal: begin
                w_rd_used  = 1'b1;
                w_imm32    = {{11{w_ins[31]}}, w_ins[31], w_ins[19:12],
                              w_ins[20], w_ins[30:21], 1'b0};
            end
            default: begin
                w_illegal  = 1'b1;
            end
        endcase

        w_rs1 = w_rs1_used ? w_ins[19:15] : 5'd0;
        w_rs2 = w_rs2_used ? w_ins[24:20] : 5'd0;
        w_rd  = w_rd_used  ? w_ins[11:7]  : 5'd0;

        // Every 32-bit immediate above already carries ins[31] in bit 31,
        // so widening to XLEN only replicates that bit upward.
        w_imm        = {XLEN{w_imm32[31]}};
        w_imm[31:0]  = w_imm32;
    end

    // ------------------------------------------------------------------
    // Handshake and hazard
    // ------------------------------------------------------------------
    logic r_out_valid;
    logic w_hazard;
    logic w_adv;
    logic w_load;

    // Unused sources decode to x0 and ex_rd_i = 0 is excluded, so x0 can
    // never produce a stall.
    assign w_hazard = bus.in_valid_i && bus.ex_load_i && (bus.ex_rd_i != 5'd0) &&
                      ((w_rs1_used && (w_rs1 == bus.ex_rd_i)) ||
                       (w_rs2_used && (w_rs2 == bus.ex_rd_i)));

    assign w_adv    = !r_out_valid || bus.out_ready_i;

    // rst is folded in so fetch never sees a transfer that reset discards.
    assign bus.in_ready_o = w_adv && !w_hazard && !bus.flush_i && !rst;

    assign w_load   = w_adv && bus.in_valid_i && !w_hazard;

    // ------------------------------------------------------------------
    // Pipeline register
    // ------------------------------------------------------------------
    logic [31:0]     r_ins;
    logic [XLEN-1:0] r_ins_addr;
    logic [4:0]      r_rs1;
    logic [4:0]      r_rs2;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_imm;
    logic            r_illegal;

    always_ff @(posedge clk) begin
        if (rst || bus.flush_i || (w_adv && !w_load)) begin
            // bubble: reset, flush (wins even under backpressure), or a free
            // slot with nothing acceptable to put in it
            r_out_valid <= 1'b0;
            r_ins       <= NOP_INS;
            r_ins_addr  <= '0;
            r_rs1       <= 5'd0;
            r_rs2       <= 5'd0;
            r_rd        <= 5'd0;
            r_imm       <= '0;
            r_illegal   <= 1'b0;
        end else if (w_load) begin
            r_out_valid <= 1'b1;
            r_ins       <= w_ins;
            r_ins_addr  <= bus.ins_addr_i;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_rd        <= w_rd;
            r_imm       <= w_imm;
            r_illegal   <= w_illegal;
        end
        // !w_adv: execute is stalled, hold everything
    end

    assign bus.out_valid_o = r_out_valid;
    assign bus.ins_o       = r_ins;
    assign bus.ins_addr_o  = r_ins_addr;
    assign bus.rs1_addr_o  = r_rs1;
    assign bus.rs2_addr_o  = r_rs2;
    assign bus.rd_addr_o   = r_rd;
    assign bus.imm_o       = r_imm;
    assign bus.illegal_o   = r_illegal;

endmodule
`default_nettype wire

// File: tb/tb_id_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_id_stage
//  Description : Directed self-checking bench for id_stage: reset, streaming
//                decode, load-use stall, backpressure, flush, illegal opcode
//                and mid-stream reset, with hand-computed expected values.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_id_stage;

    localparam int          XLEN = 32;
    localparam logic [31:0] NOP  = 32'h0000_0013;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    id_stage_if #(.XLEN(XLEN)) bus ();

    id_stage #(.XLEN(XLEN), .NOP_INS(NOP)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] ins,
                           input logic [31:0] addr, input logic [4:0] rs1,
                           input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] imm, input logic ill);
        chk({tag, ".valid"}, 32'(bus.out_valid_o), 32'(v));
        chk({tag, ".ins"},   bus.ins_o, ins);
        chk({tag, ".addr"},  bus.ins_addr_o, addr);
        chk({tag, ".rs1"},   32'(bus.rs1_addr_o), 32'(rs1));
        chk({tag, ".rs2"},   32'(bus.rs2_addr_o), 32'(rs2));
        chk({tag, ".rd"},    32'(bus.rd_addr_o), 32'(rd));
        chk({tag, ".imm"},   bus.imm_o, imm);
        chk({tag, ".ill"},   32'(bus.illegal_o), 32'(ill));
    endtask

    task automatic chk_rdy(input string tag, input logic exp);
        #1;
        chk({tag, ".in_ready"}, 32'(bus.in_ready_o), 32'(exp));
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] addr);
        bus.in_valid_i = v;
        bus.ins_i      = ins;
        bus.ins_addr_i = addr;
    endtask

    localparam logic [31:0] ADDI = 32'h0050_0093;
    localparam logic [31:0] SW   = 32'hFE20_AE23;
    localparam logic [31:0] BEQ  = 32'hFE00_0EE3;
    localparam logic [31:0] LUI  = 32'h1234_50B7;
    localparam logic [31:0] ADD  = 32'h0020_81B3;

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        bus.flush_i     = 1'b0;
        bus.ex_load_i   = 1'b0;
        bus.ex_rd_i     = 5'd0;
        bus.out_ready_i = 1'b1;
        drive(1'b1, ADDI, 32'h0000_0100);

        // ---- reset: two cycles ----
        tick();
        tick();
        chk_out("reset", 1'b0, NOP, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        chk_rdy("reset", 1'b0);
        rst = 1'b0;

        // ---- streaming, back to back ----
        drive(1'b1, ADDI, 32'h0000_0100);
        chk_rdy("s0", 1'b1);
        tick();
        chk_out("s0", 1'b1, ADDI, 32'h100, 5'd0, 5'd0, 5'd1, 32'h0000_0005, 1'b0);
        drive(1'b1, SW, 32'h0000_0104);
        chk_rdy("s1", 1'b1);
        tick();
        chk_out("s1", 1'b1, SW, 32'h104, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC, 1'b0);
        drive(1'b1, BEQ, 32'h0000_0108);
        chk_rdy("s2", 1'b1);
        tick();
        chk_out("s2", 1'b1, BEQ, 32'h108, 5'd0, 5'd0, 5'd0, 32'hFFFF_FFFC, 1'b0);
        drive(1'b1, LUI, 32'h0000_010C);
        chk_rdy("s3", 1'b1);
        tick();
        chk_out("s3", 1'b1, LUI, 32'h10C, 5'd0, 5'd0, 5'd1, 32'h1234_5000, 1'b0);

        // ---- load-use on rs1 ----
        drive(1'b1, ADD, 32'h0000_0110);
        bus.ex_load_i = 1'b1;
        bus.ex_rd_i   = 5'd1;
        chk_rdy("lu_stall", 1'b0);
        tick();
        chk_out("lu_bubble", 1'b0, NOP, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        bus.ex_load_i = 1'b0;
        chk_rdy("lu_clear", 1'b1);
        tick();
        chk_out("lu_issue", 1'b1, ADD, 32'h110, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);

        // ---- load with ex_rd = 0 never stalls ----
        drive(1'b1, ADD, 32'h0000_0114);
        bus.ex_load_i = 1'b1;
        bus.ex_rd_i   = 5'd0;
        chk_rdy("rd0", 1'b1);
        tick();
        chk_out("rd0", 1'b1, ADD, 32'h114, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);

        // ---- hazard via rs2, and a non-matching destination ----
        bus.ex_rd_i = 5'd2;
        chk_rdy("rs2_haz", 1'b0);
        bus.ex_rd_i = 5'd5;
        chk_rdy("no_haz", 1'b1);

        // ---- backpressure with hazard: output holds for 3 cycles ----
        bus.out_ready_i = 1'b0;
        bus.ex_rd_i     = 5'd1;
        drive(1'b1, ADD, 32'h0000_0118);
        for (int i = 0; i < 3; i++) begin
            chk_rdy("bp", 1'b0);
            tick();
            chk_out("bp_hold", 1'b1, ADD, 32'h114, 5'd1, 5'd2, 5'd3, 32'h0, 1'b0);
        end

        // ---- flush under backpressure ----
        bus.ex_load_i = 1'b0;
        bus.ex_rd_i   = 5'd0;
        bus.flush_i   = 1'b1;
        drive(1'b1, ADDI, 32'h0000_0300);
        chk_rdy("flush", 1'b0);
        tick();
        chk_out("flush", 1'b0, NOP, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        bus.flush_i     = 1'b0;
        bus.out_ready_i = 1'b1;
        drive(1'b0, ADDI, 32'h0000_0300);
        tick();
        chk_out("flush_drop", 1'b0, NOP, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);

        // ---- flush together with hazard ----
        bus.flush_i   = 1'b1;
        bus.ex_load_i = 1'b1;
        bus.ex_rd_i   = 5'd1;
        drive(1'b1, ADD, 32'h0000_0304);
        chk_rdy("flush_haz", 1'b0);
        tick();
        bus.flush_i   = 1'b0;
        bus.ex_load_i = 1'b0;
        bus.ex_rd_i   = 5'd0;

        // ---- illegal opcode passes through ----
        drive(1'b1, 32'hFFFF_FFFF, 32'h0000_0400);
        chk_rdy("illegal", 1'b1);
        tick();
        chk_out("illegal", 1'b1, 32'hFFFF_FFFF, 32'h400, 5'd0, 5'd0, 5'd0, 32'h0, 1'b1);

        // ---- reset mid-stream ----
        drive(1'b1, ADDI, 32'h0000_0404);
        rst = 1'b1;
        chk_rdy("mid_rst", 1'b0);
        tick();
        chk_out("mid_rst", 1'b0, NOP, 32'h0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0);
        rst = 1'b0;
        chk_rdy("post_rst", 1'b1);
        tick();
        chk_out("post_rst", 1'b1, ADDI, 32'h404, 5'd0, 5'd0, 5'd1, 32'h0000_0005, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/id_stage.md
# id_stage

Registered, parametrised RISC-V RV32I instruction-decode stage placed between the fetch register and the execute stage. It decodes the source and destination register addresses, the sign-extended immediate and an illegal-opcode flag, and holds them in a pipeline register with a valid/ready handshake. It also detects load-use hazards against the execute stage and inserts bubbles when one is found. It accepts a flush that kills the held instruction.

## Interface
- XLEN, 32: width of the immediate and instruction address outputs; must be ≥ 32.
- NOP_INS, 32'h0000_0013: instruction word used for bubbles and reset (addi x0,x0,0).

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high. One clock; reset is synchronous and active-high.
- in_valid_i  in  1  fetch holds a valid instruction.
- in_ready_o  out  1  stage accepts the instruction this cycle.
- ins_i  in  32  instruction word.
- ins_addr_i  in  XLEN  instruction address.
- flush_i  in  1  kill the held instruction and drop the input (branch/jump redirect).
- ex_load_i  in  1  instruction in execute is a load.
- ex_rd_i  in  5  destination register of the instruction in execute.
- out_valid_o  out  1  output register holds a valid decoded instruction.
- out_ready_i  in  1  execute accepts the output this cycle.
- ins_o  out  32  registered instruction.
- ins_addr_o  out  XLEN  registered address.
- rs1_addr_o, rs2_addr_o  out  5 each  source register addresses; 0 when the source is unused.
- rd_addr_o  out  5  destination register; 0 when there is no destination.
- imm_o  out  XLEN  sign-extended immediate; 0 for R-type.
- illegal_o  out  1  opcode is not one of the nine listed below.

## Operation
- The decode itself is combinational on ins_i. Opcode is ins_i[6:0].
  - OP-IMM 0010011, LOAD 0000011, JALR 1100111: rs1 used; rd = ins[11:7]; I-immediate.
  - OP 0110011: rs1, rs2 and rd used; imm = 0.
  - STORE 0100011: rs1 and rs2 used; rd = 0; S-immediate.
  - BRANCH 1100011: rs1 and rs2 used; rd = 0; B-immediate (bit 0 = 0).
  - LUI 0110111, AUIPC 0010111: rd used; U-immediate (ins[31:12] << 12).
  - JAL 1101111: rd used; J-immediate (bit 0 = 0).
  - Any other opcode: illegal = 1; rs1, rs2 and rd = 0; imm = 0.
- All immediates are sign-extended from ins[31] to XLEN.
- Hazard condition: in_valid_i && ex_load_i && ex_rd_i ≠ 0 && ((rs1 used && rs1 == ex_rd_i) || (rs2 used && rs2 == ex_rd_i)).
- Output register may advance when: adv = !out_valid_o || out_ready_i.
- in_ready_o = adv && !hazard && !flush_i.
- Register update, in priority order:
  - rst: load the bubble.
  - flush_i: load the bubble; the input is dropped.
  - adv && in_valid_i && !hazard: load the decode; out_valid_o ← 1.
  - adv otherwise (no input, or hazard): load the bubble.
  - !adv: hold all outputs.
- Bubble contents: out_valid_o = 0, ins_o = NOP_INS, ins_addr_o = 0, rs1/rs2/rd = 0, imm_o = 0, illegal_o = 0.

## Timing
- Reset values are the bubble contents listed above.
- Latency is 1 cycle: an instruction accepted at edge N appears on the outputs after edge N.
- Throughput is 1 instruction/cycle while out_ready_i = 1 and no hazard is present.
- Handshake: a transfer occurs on any edge where valid and ready are both 1. Fetch must hold ins_i and ins_addr_i stable while in_valid_i=1 && in_ready_o=0.
- Hazard: exactly one bubble is inserted per cycle the hazard persists. The same input is held and is accepted on the first edge where the hazard clears.
- Backpressure with hazard: if !adv, outputs hold regardless of hazard; no bubble overwrites the valid output.
- Flush with out_ready_i = 0: flush still wins; out_valid_o = 0 on the next cycle.
- Flush and hazard together: flush wins; in_ready_o = 0.
- rst asserted mid-stream: the bubble appears on the next edge and in_ready_o = 0 while rst is high.
- ex_rd_i = 0 never raises a hazard.
- An illegal instruction passes through as valid with illegal_o = 1; this stage does not stall or trap on it.

## Test plan
- Reset: hold rst for 2 cycles. Required: out_valid_o=0, ins_o=0x00000013, all other outputs 0, in_ready_o=0 while rst is high.
- Streaming decode of back-to-back instructions with out_ready_i=1:
  - 0x00500093 (addi x1,x0,5) → rs1=0, rd=1, imm=5.
  - 0xFE20AE23 (sw x2,-4(x1)) → rs1=1, rs2=2, rd=0, imm=0xFFFFFFFC.
  - 0xFE000EE3 (beq x0,x0,-4) → imm=0xFFFFFFFC.
  - 0x123450B7 (lui x1) → imm=0x12345000.
  - Required: each appears one cycle after acceptance, with no gaps.
- Load-use: ex_load_i=1, ex_rd_i=1, input 0x002081B3 (add x3,x1,x2) for one cycle. Required: in_ready_o=0, one bubble with out_valid_o=0, then the add is issued the cycle after ex_load_i drops. Repeat with ex_rd_i=0. Required: no stall.
- Backpressure: out_ready_i=0 for 3 cycles with a valid output and a hazard present. Required: outputs hold unchanged and in_ready_o=0.
- Flush: flush_i=1 while the output is valid and out_ready_i=0. Required: out_valid_o=0 on the next edge; the input presented that cycle is never issued.
- Illegal opcode: ins_i=0xFFFFFFFF. Required: out_valid_o=1, illegal_o=1, rs1/rs2/rd=0, imm=0.
